// File: rtl/rom_boot_loader_if.sv
// Byte-stream handshake and ROM write port shared by the boot loader and its peers.
// master = loader side (accepts bytes, drives the ROM write port).
interface rom_boot_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        rom_we;
  logic [31:0] rom_w_addr;
  logic [31:0] rom_w_data;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output rom_we,
    output rom_w_addr,
    output rom_w_data
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  rom_we,
    input  rom_w_addr,
    input  rom_w_data
  );
endinterface

// File: rtl/rom_boot_loader.sv
// Boot-load sequencer: takes a length-prefixed little-endian byte stream, writes each
// assembled word into inst_rom and keeps the core held until the image is complete.
module rom_boot_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_WORDS   = 4096,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic               i_Clk,
  input  logic               i_reset,
  input  logic               i_start,
  rom_boot_loader_if.master  bus,
  output logic               o_cpu_hold,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [12:0]        o_word_cnt
);

  localparam int              TO_W        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0]     MAX_WORDS_W = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [1:0]      byte_idx_r;
  logic [23:0]     shift_r;
  logic [12:0]     n_words_r;
  logic [12:0]     word_cnt_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            ready_r;
  logic            we_r;
  logic            hold_r;
  logic            busy_r;
  logic            done_r;
  logic            err_r;
  logic [31:0]     addr_r;
  logic [31:0]     data_r;

  logic            accept_s;
  logic            last_byte_s;
  logic            hdr_bad_s;
  logic            timeout_s;
  logic            last_word_s;
  logic            enter_hdr_s;
  logic [31:0]     word_s;

  // ready_r is only ever set in HDR/LOAD, so an accepted byte implies one of those states
  assign accept_s    = bus.byte_valid && ready_r;
  assign word_s      = {bus.byte_data, shift_r};
  assign last_byte_s = accept_s && (byte_idx_r == 2'd3);
  assign hdr_bad_s   = (word_s == 32'd0) || (word_s > MAX_WORDS_W);
  assign timeout_s   = !accept_s && (to_cnt_r == TO_LAST);
  assign last_word_s = ((word_cnt_r + 13'd1) == n_words_r);
  assign enter_hdr_s = (state_s == ST_HDR) && (state_r != ST_HDR);

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) state_s = ST_HDR;
        else         state_s = ST_IDLE;
      end
      ST_HDR: begin
        if (last_byte_s) begin
          if (hdr_bad_s) state_s = ST_ERR;
          else           state_s = ST_LOAD;
        end else if (timeout_s) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_LOAD: begin
        if (last_byte_s)    state_s = ST_WRITE;
        else if (timeout_s) state_s = ST_ERR;
        else                state_s = ST_LOAD;
      end
      ST_WRITE: begin
        if (last_word_s) state_s = ST_DONE;
        else             state_s = ST_LOAD;
      end
      ST_DONE: state_s = ST_IDLE;
      ST_ERR: begin
        if (i_start) state_s = ST_HDR;
        else         state_s = ST_ERR;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs decode the upcoming state so each one comes straight from a flop
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      hold_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      addr_r  <= 32'd0;
      data_r  <= 32'd0;
    end else begin
      ready_r <= (state_s == ST_HDR) || (state_s == ST_LOAD);
      busy_r  <= (state_s == ST_HDR) || (state_s == ST_LOAD) || (state_s == ST_WRITE);
      hold_r  <= (state_s == ST_HDR) || (state_s == ST_LOAD) || (state_s == ST_WRITE)
                 || (state_s == ST_ERR);
      done_r  <= (state_s == ST_DONE);
      err_r   <= (state_s == ST_ERR);
      we_r    <= (state_s == ST_WRITE);
      if (last_byte_s && (state_r == ST_LOAD)) begin
        addr_r <= BASE_ADDR + {17'd0, word_cnt_r, 2'b00};
        data_r <= word_s;
      end
    end
  end

  // Byte assembly, word bookkeeping and inter-byte idle timer
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      byte_idx_r <= 2'd0;
      shift_r    <= 24'd0;
      n_words_r  <= 13'd0;
      word_cnt_r <= 13'd0;
      to_cnt_r   <= {TO_W{1'b0}};
    end else begin
      if (enter_hdr_s) begin
        byte_idx_r <= 2'd0;
      end else if (accept_s) begin
        byte_idx_r <= byte_idx_r + 2'd1;
      end
      if (accept_s) begin
        shift_r <= {bus.byte_data, shift_r[23:8]};
      end
      if ((state_r == ST_HDR) && last_byte_s && !hdr_bad_s) begin
        n_words_r  <= word_s[12:0];
        word_cnt_r <= 13'd0;
      end else if (state_r == ST_WRITE) begin
        word_cnt_r <= word_cnt_r + 13'd1;
      end
      if (enter_hdr_s || accept_s) begin
        to_cnt_r <= {TO_W{1'b0}};
      end else if ((state_r == ST_HDR) || (state_r == ST_LOAD)) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end
  end

  assign bus.byte_ready = ready_r;
  assign bus.rom_we     = we_r;
  assign bus.rom_w_addr = addr_r;
  assign bus.rom_w_data = data_r;
  assign o_cpu_hold     = hold_r;
  assign o_busy         = busy_r;
  assign o_done         = done_r;
  assign o_err          = err_r;
  assign o_word_cnt     = word_cnt_r;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Directed bench for rom_boot_loader: framed loads, bad headers, back-pressure,
// idle timeout and reset in the middle of a load.
module tb_rom_boot_loader;
  logic        i_Clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        o_cpu_hold;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [12:0] o_word_cnt;

  rom_boot_loader_if bus();

  int total = 0;
  int bad   = 0;
  int done_cnt  = 0;
  int rdy_in_we = 0;
  logic [31:0] we_addr_q[$];
  logic [31:0] we_data_q[$];

  always #5 i_Clk = ~i_Clk;

  rom_boot_loader #(
    .BASE_ADDR   (32'h0000_0000),
    .MAX_WORDS   (4096),
    .TIMEOUT_CYC (16)
  ) dut (
    .i_Clk      (i_Clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .bus        (bus),
    .o_cpu_hold (o_cpu_hold),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_word_cnt (o_word_cnt)
  );

  // Log every ROM write and done pulse
  always @(negedge i_Clk) begin
    if (bus.rom_we) begin
      we_addr_q.push_back(bus.rom_w_addr);
      we_data_q.push_back(bus.rom_w_data);
      if (bus.byte_ready) rdy_in_we++;
    end
    if (o_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] status();
    return {bus.byte_ready, bus.rom_we, o_cpu_hold, o_busy, o_done, o_err};
  endfunction

  task automatic clear_log();
    we_addr_q.delete();
    we_data_q.delete();
    done_cnt  = 0;
    rdy_in_we = 0;
  endtask

  task automatic pulse_start();
    @(negedge i_Clk);
    i_start = 1'b1;
    @(negedge i_Clk);
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && n < 20) begin
      @(posedge i_Clk); #1;
      n++;
    end
    chk("byte_rdy", 32'(bus.byte_ready), 32'd1);
    @(posedge i_Clk); #1;
    if (gap) begin
      bus.byte_valid = 1'b0;
      @(posedge i_Clk); #1;
    end
  endtask

  // Little-endian; no idle after the last byte so the caller sees the following cycle
  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [31:0] v;
    v = w;
    send_byte(v[7:0],   gap);
    send_byte(v[15:8],  gap);
    send_byte(v[23:16], gap);
    send_byte(v[31:24], 1'b0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 20) begin
      @(negedge i_Clk);
      n++;
    end
    repeat (3) @(negedge i_Clk);
    chk("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  task automatic chk_we(input string tag, input int idx, input logic [31:0] addr,
                        input logic [31:0] data);
    logic [31:0] ga;
    logic [31:0] gd;
    ga = (idx < we_addr_q.size()) ? we_addr_q[idx] : 32'hxxxx_xxxx;
    gd = (idx < we_data_q.size()) ? we_data_q[idx] : 32'hxxxx_xxxx;
    chk({tag, "_addr"}, ga, addr);
    chk({tag, "_data"}, gd, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(posedge i_Clk);
    #1;
    chk("rst_status", 32'(status()), 32'd0);
    chk("rst_wcnt",   32'(o_word_cnt), 32'd0);
    chk("rst_addr",   bus.rom_w_addr, 32'd0);
    chk("rst_data",   bus.rom_w_data, 32'd0);
    i_reset = 1'b0;

    // 1: two-word image with idle gaps between bytes
    clear_log();
    pulse_start();
    chk("t1_hdr_status", 32'(status()), 32'b10_1100);
    send_word(32'd2, 1'b1);
    send_word(32'h0000_0013, 1'b1);
    chk("t1_we_lat", 32'(bus.rom_we), 32'd1);
    chk("t1_we_rdy", 32'(bus.byte_ready), 32'd0);
    send_word(32'h0010_0093, 1'b1);
    bus.byte_valid = 1'b0;
    wait_done();
    chk("t1_we_n", 32'(we_addr_q.size()), 32'd2);
    chk_we("t1_w0", 0, 32'h0, 32'h0000_0013);
    chk_we("t1_w1", 1, 32'h4, 32'h0010_0093);
    chk("t1_wcnt", 32'(o_word_cnt), 32'd2);
    chk("t1_end_status", 32'(status()), 32'd0);

    // 2: zero-length header aborts, a fresh start recovers
    clear_log();
    pulse_start();
    send_word(32'd0, 1'b1);
    chk("t2_err_status", 32'(status()), 32'b00_1001);
    repeat (3) @(posedge i_Clk);
    #1;
    chk("t2_err_held", 32'(o_err), 32'd1);
    chk("t2_no_we", 32'(we_addr_q.size()), 32'd0);
    pulse_start();
    chk("t2_restart_status", 32'(status()), 32'b10_1100);
    send_word(32'd1, 1'b1);
    send_word(32'hDEAD_BEEF, 1'b1);
    bus.byte_valid = 1'b0;
    wait_done();
    chk("t2_we_n", 32'(we_addr_q.size()), 32'd1);
    chk_we("t2_w0", 0, 32'h0, 32'hDEAD_BEEF);
    chk("t2_wcnt", 32'(o_word_cnt), 32'd1);

    // 3: oversize header (4097) aborts and stalls the source
    clear_log();
    pulse_start();
    send_word(32'd4097, 1'b1);
    chk("t3_err", 32'(o_err), 32'd1);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    repeat (5) @(posedge i_Clk);
    #1;
    chk("t3_not_ready", 32'(bus.byte_ready), 32'd0);
    chk("t3_no_we", 32'(we_addr_q.size()), 32'd0);
    chk("t3_wcnt_kept", 32'(o_word_cnt), 32'd1);
    bus.byte_valid = 1'b0;

    // 4: valid held high across the whole frame
    clear_log();
    pulse_start();
    send_word(32'd2, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0010_0093, 1'b0);
    bus.byte_valid = 1'b0;
    wait_done();
    chk("t4_we_n", 32'(we_addr_q.size()), 32'd2);
    chk_we("t4_w0", 0, 32'h0, 32'h0000_0013);
    chk_we("t4_w1", 1, 32'h4, 32'h0010_0093);
    chk("t4_rdy_in_we", 32'(rdy_in_we), 32'd0);

    // 5: source stalls one byte into the second word
    clear_log();
    pulse_start();
    send_word(32'd2, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h93, 1'b0);
    bus.byte_valid = 1'b0;
    repeat (15) @(posedge i_Clk);
    #1;
    chk("t5_err_early", 32'(o_err), 32'd0);
    @(posedge i_Clk);
    #1;
    chk("t5_err_status", 32'(status()), 32'b00_1001);
    chk("t5_we_n", 32'(we_addr_q.size()), 32'd1);
    chk_we("t5_w0", 0, 32'h0, 32'h0000_0013);
    chk("t5_wcnt", 32'(o_word_cnt), 32'd1);

    // 6: reset the cycle after the first write, then reload
    clear_log();
    pulse_start();
    send_word(32'd2, 1'b1);
    send_word(32'h0000_0013, 1'b0);
    chk("t6_we", 32'(bus.rom_we), 32'd1);
    bus.byte_valid = 1'b0;
    @(posedge i_Clk);
    #1;
    i_reset = 1'b1;
    @(posedge i_Clk);
    #1;
    chk("t6_rst_status", 32'(status()), 32'd0);
    chk("t6_rst_wcnt", 32'(o_word_cnt), 32'd0);
    chk("t6_rst_addr", bus.rom_w_addr, 32'd0);
    chk("t6_rst_data", bus.rom_w_data, 32'd0);
    i_reset = 1'b0;
    clear_log();
    pulse_start();
    send_word(32'd2, 1'b1);
    send_word(32'h0000_0013, 1'b1);
    send_word(32'h0010_0093, 1'b1);
    bus.byte_valid = 1'b0;
    wait_done();
    chk("t6_we_n", 32'(we_addr_q.size()), 32'd2);
    chk_we("t6_w0", 0, 32'h0, 32'h0000_0013);
    chk_we("t6_w1", 1, 32'h4, 32'h0010_0093);
    chk("t6_wcnt", 32'(o_word_cnt), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
